// File: rtl/t_link_pkg.sv
`default_nettype none
// ============================================================================
// Module  : t_link_pkg
// Purpose : Shared constants, helper function and data type for the
//           toggle-signalling link.
// Contents: C_W, C_DEPTH, C_SYNC_STAGES defaults; clog2(); word_t.
// Revision: 1.0  initial release
// ============================================================================
package t_link_pkg;

   localparam int C_W           = 8;
   localparam int C_DEPTH       = 4;
   localparam int C_SYNC_STAGES = 2;

   typedef logic [C_W-1:0] word_t;

   // Ceiling log2, with a floor of 1 bit so it can size any vector.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/t_toggle_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : t_toggle_sync_edge
// Purpose : Synchronises the sender's toggle line and flags each level
//           change as a one-cycle event.
// Ports   : clk      - clock
//           reset    - asynchronous active-low reset
//           t_in     - asynchronous toggle line
//           t_event  - high for one cycle per toggle (combinational)
//           t_sync   - synchronised toggle level
// Revision: 1.0  initial release
// ============================================================================
module t_toggle_sync_edge
   import t_link_pkg::*;
#(
   parameter int SYNC_STAGES = C_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic t_in,
   output logic t_event,   // "event" is a reserved word in SystemVerilog
   output logic t_sync
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_t_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync   <= '0;
         r_t_prev <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], t_in};
         r_t_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign t_sync  = r_sync[SYNC_STAGES-1];
   assign t_event = r_sync[SYNC_STAGES-1] ^ r_t_prev;

endmodule
`default_nettype wire

// File: rtl/t_toggle_receiver.sv
`default_nettype none
// ============================================================================
// Module  : t_toggle_receiver
// Purpose : Receiving end of the two-phase toggle link. Each detected toggle
//           captures data_in into a first-word-fall-through buffer and, if
//           accepted, is acknowledged by toggling ack_out.
// Ports   : clk, reset (async active-low)
//           t_in, data_in           - sender side
//           ready_in, data_out,
//           valid_out               - consumer valid/ready interface
//           pulse_out               - strobe per detected toggle
//           ack_out                 - toggles per accepted word
//           level                   - buffer occupancy
//           overflow, clr_ovf       - sticky drop flag and its clear
// Revision: 1.0  initial release
// ============================================================================
module t_toggle_receiver
   import t_link_pkg::*;
#(
   parameter int W           = C_W,
   parameter int DEPTH       = C_DEPTH,
   parameter int SYNC_STAGES = C_SYNC_STAGES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       t_in,
   input  logic [W-1:0]               data_in,
   input  logic                       ready_in,
   input  logic                       clr_ovf,
   output logic [W-1:0]               data_out,
   output logic                       valid_out,
   output logic                       pulse_out,
   output logic                       ack_out,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow
);

   localparam int PW = clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [W-1:0]  r_last;
   logic          r_pulse;
   logic          r_ack;
   logic          r_ovf;

   logic          w_event;
   logic          w_valid;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;

   t_toggle_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .t_in    (t_in),
      .t_event (w_event),
      .t_sync  ()
   );

   assign w_valid = (r_level != '0);
   assign w_pop   = w_valid & ready_in;
   // A simultaneous pop frees a slot, so a full buffer can still accept.
   assign w_push  = w_event & ((r_level < LW'(DEPTH)) | w_pop);
   assign w_drop  = w_event & ~w_push;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_last  <= '0;
         r_pulse <= 1'b0;
         r_ack   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_pulse <= w_event;
         if (w_push) begin
            r_mem[r_wptr] <= data_in;
            r_wptr        <= r_wptr + PW'(1);
            r_ack         <= ~r_ack;
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         // Remember the head word so data_out holds once the buffer empties.
         if (w_valid) r_last <= r_mem[r_rptr];
         // Set has priority over clear so a coincident drop is never lost.
         if (w_drop)       r_ovf <= 1'b1;
         else if (clr_ovf) r_ovf <= 1'b0;
      end
   end

   assign data_out  = w_valid ? r_mem[r_rptr] : r_last;
   assign valid_out = w_valid;
   assign pulse_out = r_pulse;
   assign ack_out   = r_ack;
   assign level     = r_level;
   assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_t_toggle_receiver
// Purpose : Directed self-checking bench for t_toggle_receiver.
// Revision: 1.0  initial release
// ============================================================================
module tb_t_toggle_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic       t_in;
   logic [7:0] data_in;
   logic       ready_in;
   logic       clr_ovf;
   logic [7:0] data_out;
   logic       valid_out;
   logic       pulse_out;
   logic       ack_out;
   logic [2:0] level;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   t_toggle_receiver #(.W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .t_in      (t_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .clr_ovf   (clr_ovf),
      .data_out  (data_out),
      .valid_out (valid_out),
      .pulse_out (pulse_out),
      .ack_out   (ack_out),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sender: present data, toggle, wait (bounded) for the ack to change.
   task automatic send(input logic [7:0] d);
      logic a0;
      int   n;
      data_in = d;
      a0      = ack_out;
      t_in    = ~t_in;
      n       = 0;
      while (ack_out === a0 && n < 10) begin
         tick();
         n++;
      end
      chk("ack_wait", {31'd0, ack_out !== a0}, 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
      chk({tag, "_level"}, {29'd0, level},     32'd0);
      chk({tag, "_data"},  {24'd0, data_out},  32'd0);
      chk({tag, "_ack"},   {31'd0, ack_out},   32'd0);
      chk({tag, "_pulse"}, {31'd0, pulse_out}, 32'd0);
      chk({tag, "_ovf"},   {31'd0, overflow},  32'd0);
   endtask

   initial begin
      logic [7:0] exp_q[4];

      reset = 1'b0; t_in = 1'b0; data_in = 8'h00; ready_in = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      chk_idle("reset");
      reset = 1'b1;
      tick();

      // ---- single event: toggle sampled at edge 1, pulse/ack/valid after edge 3
      data_in = 8'hA5; t_in = 1'b1;
      tick();
      chk("single_p1", {31'd0, pulse_out}, 32'd0);
      tick();
      chk("single_p2", {31'd0, pulse_out}, 32'd0);
      chk("single_a2", {31'd0, ack_out},   32'd0);
      chk("single_v2", {31'd0, valid_out}, 32'd0);
      tick();
      chk("single_p3", {31'd0, pulse_out}, 32'd1);
      chk("single_a3", {31'd0, ack_out},   32'd1);
      chk("single_v3", {31'd0, valid_out}, 32'd1);
      chk("single_d3", {24'd0, data_out},  32'hA5);
      chk("single_l3", {29'd0, level},     32'd1);
      tick();
      chk("single_p4", {31'd0, pulse_out}, 32'd0);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk("pop_level", {29'd0, level},     32'd0);
      chk("pop_valid", {31'd0, valid_out}, 32'd0);
      chk("pop_hold",  {24'd0, data_out},  32'hA5);

      // ---- handshake fill 01..04 (ack starts at 1, four toggles -> 1)
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("fill_level", {29'd0, level},    32'd4);
      chk("fill_ack",   {31'd0, ack_out},  32'd1);
      chk("fill_ovf",   {31'd0, overflow}, 32'd0);

      // ---- overflow: event while full is dropped
      data_in = 8'hFF; t_in = ~t_in;
      tick(); tick(); tick();
      chk("ovf_pulse", {31'd0, pulse_out}, 32'd1);
      chk("ovf_ack",   {31'd0, ack_out},   32'd1);
      chk("ovf_flag",  {31'd0, overflow},  32'd1);
      chk("ovf_level", {29'd0, level},     32'd4);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain1_data", {24'd0, data_out}, {24'd0, exp_q[i]});
         tick();
      end
      ready_in = 1'b0;
      chk("drain1_level", {29'd0, level}, 32'd0);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", {31'd0, overflow}, 32'd0);

      // ---- full with simultaneous pop (ack now 1)
      send(8'h11); send(8'h12); send(8'h13); send(8'h14);
      chk("full2_level", {29'd0, level}, 32'd4);
      data_in = 8'h15; t_in = ~t_in;
      tick(); tick();
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk("fullpop_pulse", {31'd0, pulse_out}, 32'd1);
      chk("fullpop_level", {29'd0, level},     32'd4);
      chk("fullpop_ack",   {31'd0, ack_out},   32'd0);
      chk("fullpop_ovf",   {31'd0, overflow},  32'd0);
      exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain2_data", {24'd0, data_out}, {24'd0, exp_q[i]});
         tick();
      end
      ready_in = 1'b0;
      chk("drain2_level", {29'd0, level}, 32'd0);

      // ---- wrap-around: 10 events streamed with ready held high
      ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(8'h30 + 8'(i));
         chk("wrap_data",  {24'd0, data_out}, 32'h30 + 32'(i));
         chk("wrap_level", {29'd0, level},    32'd1);
      end
      tick();
      ready_in = 1'b0;
      chk("wrap_empty", {29'd0, level}, 32'd0);

      // ---- reset mid-operation
      send(8'h21); send(8'h22); send(8'h23);
      chk("pre_rst_level", {29'd0, level}, 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk_idle("midrst");
      tick();
      t_in = 1'b0;           // sender's T flip-flop is reset too
      tick();
      reset = 1'b1;
      tick(); tick(); tick();
      chk("postrst_pulse", {31'd0, pulse_out}, 32'd0);
      chk("postrst_level", {29'd0, level},     32'd0);
      send(8'h5A);
      chk("postrst_data",  {24'd0, data_out}, 32'h5A);
      chk("postrst_level1", {29'd0, level},   32'd1);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      tick(); tick(); tick();
      chk("postrst_level0", {29'd0, level},     32'd0);
      chk("postrst_valid0", {31'd0, valid_out}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
